// File: rtl/irrigation_matrix_scanner.sv
// Column-scanning driver for the 5x7 LED matrix; a shadow copy of the three
// symmetric column images is taken once per frame so the display never tears.
module irrigation_matrix_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] col_2,
  input  logic [6:0] col_1,
  input  logic [6:0] col_0,
  output logic [4:0] col_sel,
  output logic [6:0] row_data,
  output logic       frame_start
);

  localparam int MAX_SB = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW     = $clog2((MAX_SB > 2) ? MAX_SB : 2);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [4:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? 5'h1F : 5'h00;
  localparam logic [6:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_col_idx;
  logic [6:0]    r_sh2, r_sh1, r_sh0;
  logic [4:0]    r_col_sel;
  logic [6:0]    r_row_data;
  logic          r_frame_start;

  logic       w_scan_end, w_blank_end, w_last_col, w_use_inputs;
  logic [2:0] w_next_idx, w_drive_idx;
  logic [6:0] w_img2, w_img1, w_img0, w_lit;
  logic [4:0] w_onehot, w_drive_sel;
  logic [6:0] w_drive_row;

  assign w_scan_end  = (r_cnt == SCAN_LAST);
  assign w_blank_end = (r_cnt == BLANK_LAST);
  assign w_last_col  = (r_col_idx == 3'd4);
  assign w_next_idx  = w_last_col ? 3'd0 : r_col_idx + 3'd1;

  // Outputs are registered, so the drive values are built for the column that
  // will be current after this edge; on a frame entry or wrap that column
  // shows the image being captured on the same edge, not the old shadow.
  assign w_use_inputs = (r_state == IDLE) || ((r_state == DRIVE) && w_scan_end && w_last_col);
  assign w_drive_idx  = (r_state == IDLE) ? 3'd0 :
                        ((r_state == DRIVE) && w_scan_end) ? w_next_idx : r_col_idx;
  assign w_img2 = w_use_inputs ? col_2 : r_sh2;
  assign w_img1 = w_use_inputs ? col_1 : r_sh1;
  assign w_img0 = w_use_inputs ? col_0 : r_sh0;

  always_comb begin
    w_lit = w_img2;
    case (w_drive_idx)
      3'd1, 3'd3: w_lit = w_img1;
      3'd2:       w_lit = w_img0;
      default:    w_lit = w_img2;
    endcase
  end

  assign w_onehot    = 5'b00001 << w_drive_idx;
  assign w_drive_sel = (COL_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
  assign w_drive_row = (ROW_ACTIVE_LOW != 0) ? ~w_lit : w_lit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_col_idx     <= '0;
      r_sh2         <= '0;
      r_sh1         <= '0;
      r_sh0         <= '0;
      r_col_sel     <= COL_OFF;
      r_row_data    <= ROW_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (!enable) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_col_idx  <= '0;
        r_col_sel  <= COL_OFF;
        r_row_data <= ROW_OFF;
      end else begin
        case (r_state)
          IDLE: begin
            r_sh2         <= col_2;
            r_sh1         <= col_1;
            r_sh0         <= col_0;
            r_col_idx     <= '0;
            r_cnt         <= '0;
            r_frame_start <= 1'b1;
            if (BLANK_CYCLES == 0) begin
              r_state    <= DRIVE;
              r_col_sel  <= w_drive_sel;
              r_row_data <= w_drive_row;
            end else begin
              r_state    <= BLANK;
              r_col_sel  <= COL_OFF;
              r_row_data <= ROW_OFF;
            end
          end
          BLANK: begin
            if (w_blank_end) begin
              r_state    <= DRIVE;
              r_cnt      <= '0;
              r_col_sel  <= w_drive_sel;
              r_row_data <= w_drive_row;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          DRIVE: begin
            if (w_scan_end) begin
              r_col_idx <= w_next_idx;
              r_cnt     <= '0;
              if (w_last_col) begin
                r_sh2         <= col_2;
                r_sh1         <= col_1;
                r_sh0         <= col_0;
                r_frame_start <= 1'b1;
              end
              if (BLANK_CYCLES == 0) begin
                r_state    <= DRIVE;
                r_col_sel  <= w_drive_sel;
                r_row_data <= w_drive_row;
              end else begin
                r_state    <= BLANK;
                r_col_sel  <= COL_OFF;
                r_row_data <= ROW_OFF;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_col_idx  <= '0;
            r_col_sel  <= COL_OFF;
            r_row_data <= ROW_OFF;
          end
        endcase
      end
    end
  end

  assign col_sel     = r_col_sel;
  assign row_data    = r_row_data;
  assign frame_start = r_frame_start;

endmodule
